instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction-stream producer for the RV32I core; the fetch-side counterpart of the instruction decoder.
- Generates sequential PCs and issues word requests to instruction memory with a valid/ready handshake.
- Buffers returned words in a small FIFO.
- Presents {instr, instr_pc} to decode with a valid/ready handshake; handles redirects from branch/jump resolution by flushing and refetching.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of 2, minimum 2.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response data valid; no backpressure.
- imem_rsp_data  in  32  instruction word.
- instr_valid  out  1  FIFO head valid to decode.
- instr_ready  in  1  decode consumes head.
- instr  out  32  head instruction word; NOP (32'h0000_0013) when empty.
- instr_pc  out  32  PC of head instruction.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC.

Behaviour:
- Reset values:
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - instr_valid=0, instr=NOP, instr_pc=0.
  - FIFO empty, state IDLE.
  - Reset mid-operation abandons any outstanding request; a late response is ignored.
- Memory protocol:
  - At most one outstanding request.
  - Response arrives ≥1 cycle after request handshake, in order.
- State machine:
  - IDLE: imem_req_valid=1 when (fifo_count < FIFO_DEPTH). On handshake: → WAIT_RSP, fetch_pc += 4.
  - WAIT_RSP: on imem_rsp_valid, push {data, pc_of_request} into FIFO. In the same cycle, imem_req_valid may assert if space remains after the push, allowing back-to-back issue; no handshake → IDLE.
  - WAIT_DISCARD: entered on redirect while a response is outstanding. The next imem_rsp_valid is dropped without a push, then → IDLE. No request is issued in this state.
- Request abandonment:
  - imem_req_valid may deassert, or imem_req_addr change, without a handshake only on redirect.
  - Otherwise address and valid are held until imem_req_ready.
- Redirect (highest priority):
  - Same cycle: FIFO flushed (count=0); fetch_pc ← redirect_pc.
  - Next cycle: instr_valid=0.
  - First request at redirect_pc is issued the cycle after redirect, unless in WAIT_DISCARD.
- Simultaneous-event rules:
  - redirect + request handshake in same cycle → WAIT_DISCARD.
  - redirect + imem_rsp_valid in same cycle → response dropped, state → IDLE.
  - redirect + instr handshake → pop ignored; flush dominates.
- Push and pop in same cycle: count unchanged; FIFO never overflows (issue gating guarantees space).
- PC arithmetic: 32-bit wrap (32'hFFFF_FFFC + 4 = 0); redirect_pc[1:0] forced to 0 on use.
- Latency: 1-cycle memory with instr_ready=1 gives first instr_valid 3 cycles after reset release, then 1 instr/cycle.
- instr/instr_pc are driven from registered FIFO storage; no combinational path from imem_rsp to instr.

Optional Feature:
- Macro: IFU_MISALIGN_CHK_EN.
- With macro:
  - Extra output instr_misaligned (1 bit), registered.
  - Asserted with a single FIFO entry {NOP, redirect_pc} when redirect_pc[1:0]≠0.
  - Fetch halts (no requests) until the next redirect or reset.
- Without macro: low bits silently masked as above; no extra port.

Decomposition:
- Shared package rv32i_defs.vh gains:
  - INSTR_NOP constant.
  - IFU state encodings IFU_IDLE / IFU_WAIT_RSP / IFU_WAIT_DISCARD.
  - PC_STEP (4).
- Sub-module ifu_fifo: parameterised synchronous FIFO of 64-bit {pc, instr} entries with push/pop/flush/count. The FSM and PC logic stay in the top.

Test Plan:
1. Reset release, RESET_PC=0, memory ready always, 1-cycle response → requests at 0x0, 0x4, 0x8…; instr_pc sequence 0x0, 0x4, 0x8, one per cycle, first valid 3 cycles after reset.
2. instr_ready=0 for 6 cycles → exactly FIFO_DEPTH=2 entries buffered; imem_req_valid low while full; no lost or duplicated PCs after release.
3. Redirect to 0x100 in the same cycle as the request handshake for 0x8 → 0x8 response dropped; next delivered instr_pc=0x100, then 0x104.
4. Redirect + imem_rsp_valid in same cycle, FIFO holding 0x10 → FIFO empties, instr_valid=0 next cycle, next instr_pc = redirect target.
5. imem_req_ready low 4 cycles → imem_req_addr stable; variable response latency 1–5 cycles → in-order delivery.
6. Assert rst while WAIT_RSP, late response one cycle after release → ignored; first delivered instr_pc=RESET_PC; with IFU_MISALIGN_CHK_EN, redirect_pc=0x102 → instr_misaligned=1, instr=NOP, instr_pc=0x102.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the RV32I instruction fetch unit:
//   INSTR_NOP        - canonical NOP (addi x0, x0, 0) shown when no instruction
//   PC_STEP          - sequential fetch increment (one 32-bit word)
//   ifu_state_e      - fetch FSM encodings IFU_IDLE / IFU_WAIT_RSP / IFU_WAIT_DISCARD
//   ifu_entry_t      - 64-bit instruction buffer entry {pc, instr}
//   align_pc()       - clears the byte-offset bits of a PC
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    IFU_IDLE         = 2'd0,
    IFU_WAIT_RSP     = 2'd1,
    IFU_WAIT_DISCARD = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifu_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// ifu_fifo
// Synchronous FIFO of {pc, instr} entries for the fetch unit.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset (pointers/count only)
//   push, push_data - write an entry (caller guarantees space)
//   pop             - consume the head entry (ignored when empty or flushing)
//   flush           - discard all entries; a push in the same cycle survives
//                     as the only entry
//   head            - registered head entry (undefined when empty)
//   count           - number of stored entries
//   empty           - count == 0
// DEPTH must be a power of two, at least 2, so pointers wrap naturally.
// -----------------------------------------------------------------------------
module ifu_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  ifu_entry_t               push_data,
  input  logic                     pop,
  input  logic                     flush,
  output ifu_entry_t               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  ifu_entry_t         mem_reg [DEPTH];
  logic [PW-1:0]      wr_ptr_reg;
  logic [PW-1:0]      rd_ptr_reg;
  logic [PW:0]        count_reg;
  logic [PW-1:0]      wr_idx;
  logic               do_pop;

  // A flush restarts the ring at slot 0, so a concurrent push lands there.
  assign wr_idx = flush ? '0 : wr_ptr_reg;
  assign do_pop = pop && (count_reg != '0) && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= PW'(push);
      count_reg  <= {{PW{1'b0}}, push};
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// RV32I instruction fetch: generates sequential PCs, issues one-outstanding
// word requests to instruction memory, buffers responses in ifu_fifo and
// presents {instr, instr_pc} to decode. Redirects flush and refetch.
// Ports:
//   clk, rst                        - clock, asynchronous active-high reset
//   imem_req_valid/ready/addr       - fetch request handshake, word address
//   imem_rsp_valid/data             - in-order response, no backpressure
//   instr_valid/ready, instr, instr_pc - head of buffer to decode (NOP when empty)
//   redirect_valid, redirect_pc     - flush and restart fetch at redirect_pc
//   instr_misaligned                - only when IFU_MISALIGN_CHK_EN is defined
// Configuration macro IFU_MISALIGN_CHK_EN: a redirect with redirect_pc[1:0]!=0
// buffers a single {NOP, redirect_pc} entry, raises instr_misaligned and halts
// fetch until the next redirect or reset. Without it the low bits are masked.
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef IFU_MISALIGN_CHK_EN
  ,
  output logic        instr_misaligned
`endif
);

  localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

  ifu_state_e    state_reg;
  logic [31:0]   fetch_pc_reg;
  logic [31:0]   req_pc_reg;
  logic          req_valid_reg;
  logic          halt_reg;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  ifu_entry_t    fifo_head;
  ifu_entry_t    fifo_push_data;
  logic          fifo_push;

  logic          pop_hs;
  logic          req_hs;
  logic          b2b_valid;
  logic          redirect_misaligned;
  logic [CW-1:0] count_after_push;
  logic [CW-1:0] count_after_pop;

`ifdef IFU_MISALIGN_CHK_EN
  assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign instr_misaligned    = halt_reg;
`else
  assign redirect_misaligned = 1'b0;
`endif

  assign instr_valid = !fifo_empty;
  assign pop_hs      = instr_valid && instr_ready;

  // Occupancy seen by the next request decision, accounting for this
  // cycle's pop (and push, while a response is landing).
  assign count_after_push = fifo_count + CW'(1) - CW'(pop_hs);
  assign count_after_pop  = fifo_count - CW'(pop_hs);

  // Back-to-back issue: while the outstanding response lands, the next
  // request can go out in the same cycle if the buffer still has room.
  assign b2b_valid = (state_reg == IFU_WAIT_RSP) && imem_rsp_valid &&
                     !halt_reg && (count_after_push < DEPTH_C);

  assign imem_req_valid = req_valid_reg || b2b_valid;
  assign imem_req_addr  = fetch_pc_reg;
  assign req_hs         = imem_req_valid && imem_req_ready;

  always_comb begin
    fifo_push      = 1'b0;
    fifo_push_data = '0;
    if (redirect_valid) begin
      // Flush dominates; only the misaligned marker entry may survive it.
      fifo_push            = redirect_misaligned;
      fifo_push_data.pc    = redirect_pc;
      fifo_push_data.instr = INSTR_NOP;
    end else begin
      fifo_push            = (state_reg == IFU_WAIT_RSP) && imem_rsp_valid;
      fifo_push_data.pc    = req_pc_reg;
      fifo_push_data.instr = imem_rsp_data;
    end
  end

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (pop_hs),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign instr    = fifo_empty ? INSTR_NOP : fifo_head.instr;
  assign instr_pc = fifo_empty ? 32'h0     : fifo_head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IFU_IDLE;
      fetch_pc_reg  <= RESET_PC;
      req_pc_reg    <= RESET_PC;
      req_valid_reg <= 1'b0;
      halt_reg      <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_reg <= align_pc(redirect_pc);
      halt_reg     <= redirect_misaligned;
      // A request still in flight after this edge must have its response
      // swallowed: either one was just accepted, or the pending one has not
      // arrived yet.
      if (req_hs ||
          ((state_reg != IFU_IDLE) && !imem_rsp_valid)) begin
        state_reg     <= IFU_WAIT_DISCARD;
        req_valid_reg <= 1'b0;
      end else begin
        state_reg     <= IFU_IDLE;
        req_valid_reg <= !redirect_misaligned;
      end
    end else begin
      case (state_reg)
        IFU_IDLE: begin
          if (req_hs) begin
            req_pc_reg    <= fetch_pc_reg;
            fetch_pc_reg  <= fetch_pc_reg + PC_STEP;
            state_reg     <= IFU_WAIT_RSP;
            req_valid_reg <= 1'b0;
          end else begin
            // No push happens in IDLE, so once raised this stays high until
            // accepted.
            req_valid_reg <= !halt_reg && (count_after_pop < DEPTH_C);
          end
        end
        IFU_WAIT_RSP: begin
          if (imem_rsp_valid) begin
            if (req_hs) begin
              req_pc_reg   <= fetch_pc_reg;
              fetch_pc_reg <= fetch_pc_reg + PC_STEP;
            end else begin
              // Keeps a stalled back-to-back request asserted with the same
              // address once the FSM falls back to IDLE.
              state_reg     <= IFU_IDLE;
              req_valid_reg <= !halt_reg && (count_after_push < DEPTH_C);
            end
          end
        end
        IFU_WAIT_DISCARD: begin
          if (imem_rsp_valid) begin
            state_reg     <= IFU_IDLE;
            req_valid_reg <= !halt_reg && (count_after_pop < DEPTH_C);
          end
        end
        default: begin
          state_reg     <= IFU_IDLE;
          req_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
`ifdef IFU_MISALIGN_CHK_EN
  logic        instr_misaligned;
`endif

  int checks   = 0;
  int failures = 0;

  // memory model controls
  logic        mem_auto  = 1'b1;
  logic        var_lat   = 1'b0;
  logic        man_rsp_v = 1'b0;
  logic [31:0] man_rsp_d = 32'h0;
  logic        rsp_v     = 1'b0;
  logic [31:0] rsp_d     = 32'h0;
  logic        pend      = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt  = 0;
  int          hs_cnt    = 0;

  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IFU_MISALIGN_CHK_EN
    ,
    .instr_misaligned (instr_misaligned)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h1357_9BD0) | 32'h0000_0003;
  endfunction

  function automatic int lat_now(input logic vl, input int n);
    if (!vl) return 1;
    case (n % 5)
      0: return 3;
      1: return 1;
      2: return 5;
      3: return 2;
      default: return 4;
    endcase
  endfunction

  assign imem_rsp_valid = mem_auto ? rsp_v : man_rsp_v;
  assign imem_rsp_data  = mem_auto ? rsp_d : man_rsp_d;

  // Instruction memory: one outstanding request, response 'latency' edges
  // after the request handshake.
  always @(posedge clk) begin
    if (rst || !mem_auto) begin
      rsp_v <= 1'b0;
      pend  <= 1'b0;
    end else begin
      rsp_v <= 1'b0;
      if (pend) begin
        if (pend_cnt <= 1) begin
          rsp_v <= 1'b1;
          rsp_d <= mem_word(pend_addr);
          pend  <= 1'b0;
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        hs_cnt <= hs_cnt + 1;
        if (lat_now(var_lat, hs_cnt) <= 1) begin
          rsp_v <= 1'b1;
          rsp_d <= mem_word(imem_req_addr);
        end else begin
          pend      <= 1'b1;
          pend_addr <= imem_req_addr;
          pend_cnt  <= lat_now(var_lat, hs_cnt) - 1;
        end
      end
    end
  end

  // Delivery monitor: one line per consumed instruction.
  always @(posedge clk) begin
    if (!rst && instr_valid && instr_ready && !redirect_valid) begin
      got_pc.push_back(instr_pc);
      got_ins.push_back(instr);
      $display("DELIVER pc=%08h instr=%08h", instr_pc, instr);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    got_pc.delete();
    got_ins.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_ready = 1'b0;
    imem_req_ready = 1'b1;
    tick(3);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL rst_req_valid got=%0b exp=0", imem_req_valid);
    end
    checks++;
    if (imem_req_addr !== 32'h0) begin
      failures++; $display("FAIL rst_req_addr got=%08h exp=00000000", imem_req_addr);
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL rst_instr_valid got=%0b exp=0", instr_valid);
    end
    checks++;
    if (instr !== 32'h0000_0013) begin
      failures++; $display("FAIL rst_instr got=%08h exp=00000013", instr);
    end
    checks++;
    if (instr_pc !== 32'h0) begin
      failures++; $display("FAIL rst_instr_pc got=%08h exp=00000000", instr_pc);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    instr_ready = 1'b1;
    rst = 1'b0;
    tick(1);
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL stream_c1 got v=%0b rq=%0b addr=%08h exp v=0 rq=1 addr=00000000",
               instr_valid, imem_req_valid, imem_req_addr);
    end
    tick(1);
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin
      failures++;
      $display("FAIL stream_c2 got v=%0b rq=%0b addr=%08h exp v=0 rq=1 addr=00000004",
               instr_valid, imem_req_valid, imem_req_addr);
    end
    tick(1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick(1);
      exp_pc = 32'(4 * k);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
        failures++;
        $display("FAIL stream_pc%0d got v=%0b pc=%08h instr=%08h exp v=1 pc=%08h instr=%08h",
                 k, instr_valid, instr_pc, instr, exp_pc, mem_word(exp_pc));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    instr_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      checks++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h14) begin
        failures++;
        $display("FAIL bp_hold%0d got rq=%0b v=%0b pc=%08h exp rq=0 v=1 pc=00000014",
                 c, imem_req_valid, instr_valid, instr_pc);
      end
    end
    got_pc.delete();
    got_ins.delete();
    instr_ready = 1'b1;
    tick(16);
    for (int i = 0; i < 6; i++) begin
      exp_pc = 32'h14 + 32'(4 * i);
      checks++;
      if (got_pc.size() <= i) begin
        failures++; $display("FAIL bp_seq%0d got none exp pc=%08h", i, exp_pc);
      end else if (got_pc[i] !== exp_pc || got_ins[i] !== mem_word(exp_pc)) begin
        failures++;
        $display("FAIL bp_seq%0d got pc=%08h instr=%08h exp pc=%08h instr=%08h",
                 i, got_pc[i], got_ins[i], exp_pc, mem_word(exp_pc));
      end
    end
  endtask

  task automatic test_redirect_handshake();
    logic [31:0] exp_pc;
    instr_ready = 1'b1;
    imem_req_ready = 1'b1;
    do_reset();
    tick(3);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
      failures++;
      $display("FAIL rdh_req8 got rq=%0b addr=%08h exp rq=1 addr=00000008",
               imem_req_valid, imem_req_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    got_pc.delete();
    got_ins.delete();
    tick(1);
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rdh_after got v=%0b rq=%0b exp v=0 rq=0", instr_valid, imem_req_valid);
    end
    tick(12);
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h100 + 32'(4 * i);
      checks++;
      if (got_pc.size() <= i) begin
        failures++; $display("FAIL rdh_seq%0d got none exp pc=%08h", i, exp_pc);
      end else if (got_pc[i] !== exp_pc || got_ins[i] !== mem_word(exp_pc)) begin
        failures++;
        $display("FAIL rdh_seq%0d got pc=%08h instr=%08h exp pc=%08h instr=%08h",
                 i, got_pc[i], got_ins[i], exp_pc, mem_word(exp_pc));
      end
    end
  endtask

  task automatic test_redirect_response();
    bit seen;
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    tick(1);
    redirect_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (instr_valid === 1'b1) seen = 1'b1;
      else tick(1);
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL rdr_wait got no instr_valid exp instr_valid=1 within 20 cycles");
    end
    checks++;
    if (instr_pc !== 32'h10 || imem_rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rdr_setup got pc=%08h rsp=%0b exp pc=00000010 rsp=1", instr_pc, imem_rsp_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    got_pc.delete();
    got_ins.delete();
    tick(1);
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin
      failures++;
      $display("FAIL rdr_flush got v=%0b instr=%08h exp v=0 instr=00000013", instr_valid, instr);
    end
    instr_ready = 1'b1;
    tick(10);
    checks++;
    if (got_pc.size() == 0) begin
      failures++; $display("FAIL rdr_next got none exp pc=00000200");
    end else if (got_pc[0] !== 32'h200 || got_ins[0] !== mem_word(32'h200)) begin
      failures++;
      $display("FAIL rdr_next got pc=%08h instr=%08h exp pc=00000200 instr=%08h",
               got_pc[0], got_ins[0], mem_word(32'h200));
    end
  endtask

  task automatic test_req_stall();
    bit seen;
    logic [31:0] exp_pc;
    instr_ready = 1'b1;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    tick(1);
    redirect_valid = 1'b0;
    got_pc.delete();
    got_ins.delete();
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      if (imem_req_valid === 1'b1) seen = 1'b1;
      else tick(1);
    end
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick(1);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin
        failures++;
        $display("FAIL stall_hold%0d got rq=%0b addr=%08h exp rq=1 addr=00000300",
                 c, imem_req_valid, imem_req_addr);
      end
    end
    var_lat = 1'b1;
    imem_req_ready = 1'b1;
    tick(60);
    for (int i = 0; i < 8; i++) begin
      exp_pc = 32'h300 + 32'(4 * i);
      checks++;
      if (got_pc.size() <= i) begin
        failures++; $display("FAIL varlat_seq%0d got none exp pc=%08h", i, exp_pc);
      end else if (got_pc[i] !== exp_pc || got_ins[i] !== mem_word(exp_pc)) begin
        failures++;
        $display("FAIL varlat_seq%0d got pc=%08h instr=%08h exp pc=%08h instr=%08h",
                 i, got_pc[i], got_ins[i], exp_pc, mem_word(exp_pc));
      end
    end
    // let the buffer fill and the last request complete
    instr_ready = 1'b0;
    tick(20);
    var_lat = 1'b0;
  endtask

  task automatic test_reset_midflight();
    mem_auto = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    tick(1);
    redirect_valid = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400) begin
      failures++;
      $display("FAIL mid_req got rq=%0b addr=%08h exp rq=1 addr=00000400",
               imem_req_valid, imem_req_addr);
    end
    tick(1);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL mid_wait got rq=%0b exp rq=0", imem_req_valid);
    end
    instr_ready = 1'b1;
    rst = 1'b1;
    tick(1);
    got_pc.delete();
    got_ins.delete();
    rst = 1'b0;
    man_rsp_v = 1'b1;
    man_rsp_d = 32'hDEAD_BEEF;
    tick(1);
    man_rsp_v = 1'b0;
    mem_auto = 1'b1;
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL mid_late got v=%0b rq=%0b addr=%08h exp v=0 rq=1 addr=00000000",
               instr_valid, imem_req_valid, imem_req_addr);
    end
    tick(8);
    checks++;
    if (got_pc.size() == 0) begin
      failures++; $display("FAIL mid_first got none exp pc=00000000");
    end else if (got_pc[0] !== 32'h0 || got_ins[0] !== mem_word(32'h0)) begin
      failures++;
      $display("FAIL mid_first got pc=%08h instr=%08h exp pc=00000000 instr=%08h",
               got_pc[0], got_ins[0], mem_word(32'h0));
    end
  endtask

`ifdef IFU_MISALIGN_CHK_EN
  task automatic test_misalign();
    bit seen;
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    tick(1);
    redirect_valid = 1'b0;
    checks++;
    if (instr_misaligned !== 1'b1 || instr_valid !== 1'b1 ||
        instr !== 32'h0000_0013 || instr_pc !== 32'h102) begin
      failures++;
      $display("FAIL mis_entry got mis=%0b v=%0b instr=%08h pc=%08h exp mis=1 v=1 instr=00000013 pc=00000102",
               instr_misaligned, instr_valid, instr, instr_pc);
    end
    for (int c = 0; c < 6; c++) begin
      tick(1);
      checks++;
      if (imem_req_valid !== 1'b0) begin
        failures++; $display("FAIL mis_halt%0d got rq=%0b exp rq=0", c, imem_req_valid);
      end
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick(1);
    redirect_valid = 1'b0;
    checks++;
    if (instr_misaligned !== 1'b0) begin
      failures++; $display("FAIL mis_clear got mis=%0b exp mis=0", instr_misaligned);
    end
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      if (imem_req_valid === 1'b1) seen = 1'b1;
      else tick(1);
    end
    checks++;
    if (!seen || imem_req_addr !== 32'h200) begin
      failures++;
      $display("FAIL mis_resume got seen=%0b addr=%08h exp seen=1 addr=00000200", seen, imem_req_addr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_handshake();
    test_redirect_response();
    test_req_stall();
    test_reset_midflight();
`ifdef IFU_MISALIGN_CHK_EN
    test_misalign();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
